// File: rtl/booth_mul4_seq.sv
// Sequential signed radix-2 Booth multiplier: one add/sub/no-op plus
// one arithmetic shift per cycle, WIDTH cycles per product.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, clears all state
//   start        request, sampled only while busy==0
//   multiplicand signed operand M (two's complement)
//   multiplier   signed operand Q (two's complement)
//   busy         high in RUN and DONE
//   done         one-cycle pulse, product valid from this cycle on
//   product      signed M*Q, 2*WIDTH bits, held until next accept
module booth_mul4_seq #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   // Partial product is one bit wider than the operands so that
   // subtracting M = -2^(WIDTH-1) cannot overflow.
   logic [WIDTH:0]   acc;
   logic [WIDTH:0]   m_ext;
   logic [WIDTH-1:0] qr;
   logic             q_1;
   logic [CW-1:0]    cnt;

   logic             accept;
   logic             last;
   logic             op;
   logic             arith;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   acc_nx;
   logic [WIDTH:0]   acc_sh;
   logic [WIDTH-1:0] qr_sh;

   assign accept = (state == IDLE) && start;
   assign last   = (cnt == CW'(WIDTH - 1));

   // Booth recoding of the current multiplier bit pair.
   // op follows the add/sub unit: 0 add, 1 subtract.
   always_comb begin
      op    = 1'b0;
      arith = 1'b0;
      unique case ({qr[0], q_1})
         2'b01: begin
            arith = 1'b1;
         end
         2'b10: begin
            op    = 1'b1;
            arith = 1'b1;
         end
         default: begin
            arith = 1'b0;
         end
      endcase
   end

   // Add/sub datapath; carry out beyond WIDTH+1 bits is dropped.
   always_comb begin
      sum = op ? (acc - m_ext) : (acc + m_ext);
   end

   assign acc_nx = arith ? sum : acc;

   // Arithmetic right shift of {acc, qr, q_1}.
   assign acc_sh = {acc_nx[WIDTH], acc_nx[WIDTH:1]};
   assign qr_sh  = {acc_nx[0], qr[WIDTH-1:1]};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (start) state_nx = RUN;
         end
         RUN: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Outputs decoded from the registered state only
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         m_ext   <= '0;
         qr      <= '0;
         q_1     <= 1'b0;
         cnt     <= '0;
         product <= '0;
      end else if (accept) begin
         acc   <= '0;
         m_ext <= {multiplicand[WIDTH-1], multiplicand};
         qr    <= multiplier;
         q_1   <= 1'b0;
         cnt   <= '0;
      end else if (state == RUN) begin
         acc <= acc_sh;
         qr  <= qr_sh;
         q_1 <= qr[0];
         cnt <= cnt + CW'(1);
         if (last) begin
            product <= {acc_sh[WIDTH-1:0], qr_sh};
         end
      end
   end

endmodule

// File: tb/tb_booth_mul4_seq.sv
// Scoreboard bench for booth_mul4_seq (WIDTH=4).
// Driver pushes expected products; a monitor pops them on each done.
module tb_booth_mul4_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] multiplicand;
   logic [3:0] multiplier;
   logic       busy;
   logic       done;
   logic [7:0] product;

   booth_mul4_seq #(.WIDTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] p;
      int         acc;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   last_acc;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   // Waits (at negedges) until the DUT is idle, bounded.
   task automatic wait_idle();
      int t = 0;
      while (busy !== 1'b0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   // Issues one accepted multiply; returns at the negedge after accept.
   task automatic mul(input logic [3:0] m, input logic [3:0] q,
                      input logic [7:0] e, input string nm);
      exp_t x;
      wait_idle();
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      @(posedge clk);
      #1;
      x.p = e;
      x.acc = cyc;
      x.name = nm;
      sb.push_back(x);
      last_acc = cyc;
      start = 1'b0;
      multiplicand = 4'($urandom);
      multiplier   = 4'($urandom);
      @(negedge clk);
   endtask

   // Monitor: every done pulse must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               chk("spurious_done", {31'd0, done}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_product"}, {24'd0, product}, {24'd0, e.p});
               chk({e.name, "_latency"}, cyc - e.acc, 32'd4);
               @(negedge clk);
               chk({e.name, "_pulse"}, {31'd0, done}, 32'd0);
               chk({e.name, "_busy_drop"}, {31'd0, busy}, 32'd0);
            end
         end
      end
   end

   initial begin
      logic [7:0] ref_p;
      int t;
      rst = 1'b1;
      start = 1'b0;
      multiplicand = '0;
      multiplier = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_product", {24'd0, product}, 32'h00);
      rst = 1'b0;

      mul(4'd0, 4'd7, 8'h00, "0x7");
      mul(4'd3, 4'd5, 8'h0F, "3x5");
      mul(4'd7, 4'hF, 8'hF9, "7xm1");
      mul(4'h8, 4'h8, 8'h40, "m8xm8");
      mul(4'h8, 4'd7, 8'hC8, "m8x7");

      // start pulses during RUN with other operands must be ignored
      mul(4'd2, 4'hD, 8'hFA, "2xm3");
      multiplicand = 4'd7;
      multiplier   = 4'd7;
      start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;

      // start held high: back-to-back accepts every 6 cycles
      wait_idle();
      start = 1'b1;
      begin
         logic [3:0] bm[3] = '{4'd5, 4'hC, 4'd1};
         logic [3:0] bq[3] = '{4'd5, 4'd3, 4'hF};
         logic [7:0] be[3] = '{8'h19, 8'hF4, 8'hFF};
         exp_t x;
         for (int i = 0; i < 3; i++) begin
            wait_idle();
            multiplicand = bm[i];
            multiplier   = bq[i];
            @(posedge clk);
            #1;
            x.p = be[i];
            x.acc = cyc;
            x.name = "b2b";
            sb.push_back(x);
            if (i > 0) chk("b2b_spacing", cyc - last_acc, 32'd6);
            last_acc = cyc;
            @(negedge clk);
         end
      end
      start = 1'b0;

      // reset wins over a coincident start
      wait_idle();
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      multiplicand = 4'd3;
      multiplier = 4'd3;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      chk("rst_start_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("rst_start_idle", {31'd0, busy}, 32'd0);

      // reset at iteration 2 aborts 6x3: no done, product cleared
      wait_idle();
      multiplicand = 4'd6;
      multiplier = 4'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_product", {24'd0, product}, 32'h00);
      repeat (6) @(negedge clk);
      mul(4'd2, 4'd3, 8'h06, "2x3");

      // exhaustive sweep against a signed multiply reference
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            ref_p = 8'($signed(4'(i)) * $signed(4'(j)));
            mul(4'(i), 4'(j), ref_p, "sweep");
         end
      end

      t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("drain", sb.size(), 32'd0);
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
